// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RxD, samples each bit at its centre using a
// bit-period counter, and hands received bytes to the host over valid/ready.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [7:0]             shift_reg, shift_next;
    logic [7:0]             rx_data_reg, rx_data_next;
    logic                   rx_valid_reg, rx_valid_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   overrun_err_reg, overrun_err_next;

    // Preset to idle-high so releasing reset onto a high line never looks like a start edge.
    assign rxs = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_reg        <= '1;
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            sync_reg        <= {sync_reg[SYNC_STAGES-2:0], RxD};
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            bit_idx_reg     <= bit_idx_next;
            shift_reg       <= shift_next;
            rx_data_reg     <= rx_data_next;
            rx_valid_reg    <= rx_valid_next;
            frame_err_reg   <= frame_err_next;
            overrun_err_reg <= overrun_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        bit_idx_next     = bit_idx_reg;
        shift_next       = shift_reg;
        rx_data_next     = rx_data_reg;
        rx_valid_next    = rx_valid_reg;
        frame_err_next   = 1'b0;
        overrun_err_next = 1'b0;

        if (rx_valid_reg && rx_ready) begin
            rx_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rxs ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rxs) begin
                        state_next = IDLE;
                        // A consumer accepting on this very edge frees the slot for the new byte.
                        if (!rx_valid_reg || rx_ready) begin
                            rx_data_next  = shift_reg;
                            rx_valid_next = 1'b1;
                        end else begin
                            overrun_err_next = 1'b1;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign rx_busy     = (state_reg != IDLE);
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx at 16 clocks/bit, plus a
// 434 clocks/bit instance exercised at +/-3% line rate.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int H   = N / 2;
    localparam int LAT = 2 + 1 + H + 9 * N;   // RxD fall to rx_valid rise
    localparam int N2  = 434;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd16, rxd434;
    logic       ready16, ready434;
    logic [7:0] data16, data434;
    logic       valid16, valid434;
    logic       busy16, busy434;
    logic       ferr16, ferr434;
    logic       oerr16, oerr434;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .RxD(rxd16),
        .rx_data(data16), .rx_valid(valid16), .rx_ready(ready16),
        .rx_busy(busy16), .frame_err(ferr16), .overrun_err(oerr16)
    );

    uart_rx #(.CLKS_PER_BIT(N2), .SYNC_STAGES(2)) dut434 (
        .clk(clk), .resetn(resetn), .RxD(rxd434),
        .rx_data(data434), .rx_valid(valid434), .rx_ready(ready434),
        .rx_busy(busy434), .frame_err(ferr434), .overrun_err(oerr434)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed event counters (cycles each flag was high), sampled mid-cycle.
    int   ferr_cnt = 0, oerr_cnt = 0, busy_cnt = 0;
    int   ferr2_cnt = 0, oerr2_cnt = 0;
    int   valid_rise_cyc = 0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (ferr16)  ferr_cnt  <= ferr_cnt + 1;
        if (oerr16)  oerr_cnt  <= oerr_cnt + 1;
        if (busy16)  busy_cnt  <= busy_cnt + 1;
        if (ferr434) ferr2_cnt <= ferr2_cnt + 1;
        if (oerr434) oerr2_cnt <= oerr2_cnt + 1;
        if (valid16 && !valid_prev) valid_rise_cyc <= cyc;
        valid_prev <= valid16;
    end

    int checks = 0, failures = 0;
    int exp_ferr = 0, exp_oerr = 0;
    int fall_cyc = 0;
    int b0;
    logic [7:0] hold_data;
    logic       hold_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int bitlen, input bit sel);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) fall_cyc = cyc;
            if (sel) rxd434 = fr[i];
            else     rxd16  = fr[i];
            repeat (bitlen - 1) @(negedge clk);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic consume16();
        @(negedge clk) ready16 = 1'b1;
        @(negedge clk) ready16 = 1'b0;
        #1;
    endtask

    initial begin
        resetn = 1'b0; rxd16 = 1'b1; rxd434 = 1'b1; ready16 = 1'b0; ready434 = 1'b0;
        wait_cycles(3);
        check("reset_data",  data16,  8'h00);
        check("reset_valid", valid16, 1'b0);
        check("reset_busy",  busy16,  1'b0);
        check("reset_ferr",  ferr16,  1'b0);
        check("reset_oerr",  oerr16,  1'b0);
        @(negedge clk) resetn = 1'b1;
        wait_cycles(5);

        // 1: single frame, held until accepted
        drive_frame(8'hA5, 1'b1, N, 1'b0);
        #1;
        $display("frame A5 rx_data=%02h rx_valid=%0b latency=%0d", data16, valid16, valid_rise_cyc - fall_cyc);
        check("t1_latency", valid_rise_cyc - fall_cyc, LAT);
        check("t1_data", data16, 8'hA5);
        check("t1_valid", valid16, 1'b1);
        wait_cycles(20);
        check("t1_hold_valid", valid16, 1'b1);
        check("t1_hold_data", data16, 8'hA5);
        @(negedge clk) ready16 = 1'b1;
        #1 check("t1_valid_before_accept", valid16, 1'b1);
        @(negedge clk) ready16 = 1'b0;
        #1 check("t1_valid_cleared", valid16, 1'b0);

        // 2: short glitch shorter than half a bit
        wait_cycles(5);
        b0 = busy_cnt;
        @(negedge clk) rxd16 = 1'b0;
        repeat (5) @(negedge clk);
        rxd16 = 1'b1;
        wait_cycles(30);
        $display("glitch busy_cycles=%0d", busy_cnt - b0);
        check("t2_busy_cycles", busy_cnt - b0, H);
        check("t2_busy_now", busy16, 1'b0);
        check("t2_valid", valid16, 1'b0);
        check("t2_ferr", ferr_cnt, exp_ferr);
        check("t2_oerr", oerr_cnt, exp_oerr);

        // 3: bad stop bit followed by a break
        drive_frame(8'h3C, 1'b0, N, 1'b0);
        exp_ferr++;
        wait_cycles(40);
        $display("frame 3C stop=0 frame_err_cycles=%0d busy=%0b", ferr_cnt, busy16);
        check("t3_ferr", ferr_cnt, exp_ferr);
        check("t3_valid", valid16, 1'b0);
        check("t3_busy_in_break", busy16, 1'b1);
        @(negedge clk) rxd16 = 1'b1;
        wait_cycles(5);
        check("t3_busy_after", busy16, 1'b0);

        // 4a: back-to-back with no consumer -> overrun, first byte kept
        drive_frame(8'h11, 1'b1, N, 1'b0);
        drive_frame(8'h22, 1'b1, N, 1'b0);
        exp_oerr++;
        #1;
        $display("frames 11,22 no-ready rx_data=%02h overrun_cycles=%0d", data16, oerr_cnt);
        check("t4a_data", data16, 8'h11);
        check("t4a_valid", valid16, 1'b1);
        check("t4a_oerr", oerr_cnt, exp_oerr);
        check("t4a_ferr", ferr_cnt, exp_ferr);

        // 4b: 0x11 overruns again, 0x22 lands on the accepting edge
        fork
            begin
                drive_frame(8'h11, 1'b1, N, 1'b0);
                drive_frame(8'h22, 1'b1, N, 1'b0);
            end
            begin
                repeat (10 * N + LAT) @(negedge clk);
                ready16 = 1'b1;
                @(negedge clk) ready16 = 1'b0;
            end
        join
        exp_oerr++;
        #1;
        $display("frames 11,22 ready-on-stop rx_data=%02h overrun_cycles=%0d", data16, oerr_cnt);
        check("t4b_data", data16, 8'h22);
        check("t4b_valid", valid16, 1'b1);
        check("t4b_oerr", oerr_cnt, exp_oerr);

        // 5: reset during data bit 4 of 0xFF
        @(negedge clk) rxd16 = 1'b0;
        repeat (N - 1) @(negedge clk);
        @(negedge clk) rxd16 = 1'b1;
        repeat (4 * N - 1) @(negedge clk);
        repeat (2) @(negedge clk);
        #1 check("t5_busy_pre", busy16, 1'b1);
        #1 resetn = 1'b0;
        #1;
        $display("reset mid-frame rx_data=%02h rx_valid=%0b rx_busy=%0b", data16, valid16, busy16);
        check("t5_data_rst", data16, 8'h00);
        check("t5_valid_rst", valid16, 1'b0);
        check("t5_busy_rst", busy16, 1'b0);
        repeat (20) @(negedge clk);
        resetn = 1'b1;
        wait_cycles(10);
        check("t5_valid_rel", valid16, 1'b0);
        check("t5_busy_rel", busy16, 1'b0);
        drive_frame(8'h5A, 1'b1, N, 1'b0);
        #1;
        $display("frame 5A after reset rx_data=%02h", data16);
        check("t5_data", data16, 8'h5A);
        check("t5_valid", valid16, 1'b1);
        check("t5_ferr", ferr_cnt, exp_ferr);
        check("t5_oerr", oerr_cnt, exp_oerr);
        consume16();

        // Randomized frames against a byte-slot model
        hold_data  = 8'h5A;
        hold_valid = 1'b0;
        for (int it = 0; it < 12; it++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            drive_frame(b, stop, N, 1'b0);
            if (!stop) begin
                exp_ferr++;
            end else if (hold_valid) begin
                exp_oerr++;
            end else begin
                hold_data  = b;
                hold_valid = 1'b1;
            end
            @(negedge clk) rxd16 = 1'b1;
            wait_cycles($urandom_range(2, 12));
            $display("rand frame %02h stop=%0b rx_data=%02h rx_valid=%0b", b, stop, data16, valid16);
            check("rand_data", data16, hold_data);
            check("rand_valid", valid16, hold_valid);
            check("rand_ferr", ferr_cnt, exp_ferr);
            check("rand_oerr", oerr_cnt, exp_oerr);
            if ($urandom_range(0, 1) == 1) begin
                consume16();
                hold_valid = 1'b0;
            end
        end

        // 6: 434 clocks/bit with a 3% fast and a 3% slow transmitter
        drive_frame(8'h00, 1'b1, 421, 1'b1);
        wait_cycles(50);
        $display("frame 00 @421 rx_data=%02h rx_valid=%0b", data434, valid434);
        check("t6_data00", data434, 8'h00);
        check("t6_valid00", valid434, 1'b1);
        @(negedge clk) ready434 = 1'b1;
        @(negedge clk) ready434 = 1'b0;
        drive_frame(8'hFF, 1'b1, 447, 1'b1);
        wait_cycles(50);
        $display("frame FF @447 rx_data=%02h rx_valid=%0b", data434, valid434);
        check("t6_dataFF", data434, 8'hFF);
        check("t6_validFF", valid434, 1'b1);
        check("t6_ferr", ferr2_cnt, 0);
        check("t6_oerr", oerr2_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
